slatch_bank: RTL and testbench
==============================

Name: slatch_bank

Overview:
Parametrised successor to the single-bit enabled scan latch. It is a bank of CHANNELS registers, each WIDTH bits wide, clocked by sys_clk. Loads are qualified by a strobe (rising edge or level) and a per-channel enable. An optional shadow stage with a commit strobe gives glitch-free group updates, and a sticky per-channel overrun flag reports lost loads. It sits in TOM/JERRY register paths wherever a group of control latches must update together.

Parameters:
WIDTH, 16, data bits per channel (1..32)
CHANNELS, 4, number of independent channels (1..16)
DOUBLE_BUF, 1, 1 = stage+commit shadow register; 0 = direct load into q
STROBE_EDGE, 1, 1 = load on rising edge of strobe; 0 = load every cycle strobe is high

Ports:
sys_clk  in  1  single system clock; all state changes on its rising edge
reset  in  1  asynchronous, active-high reset
strobe  in  1  latch strobe (equivalent of the old latch clk), sampled on sys_clk
en  in  CHANNELS  per-channel load enable
d  in  WIDTH  shared load data
commit  in  1  transfer all pending stages to q (DOUBLE_BUF=1 only; ignored otherwise)
overrun_clr  in  1  clear all overrun flags
q  out  CHANNELS*WIDTH  latched outputs; channel i at bits [i*WIDTH +: WIDTH]
qn  out  CHANNELS*WIDTH  bitwise inverse of q, registered alongside q
pending  out  CHANNELS  stage loaded but not yet committed (always 0 when DOUBLE_BUF=0)
overrun  out  CHANNELS  sticky: a load was overwritten before it was committed

Behaviour:
- Reset (async, immediate): strobe_d=1 so a strobe held high through reset is not an edge; stage=0; q=0; qn=all ones; pending=0; overrun=0.
- Load qualifier: ld = strobe & ~strobe_d when STROBE_EDGE=1, else ld = strobe. strobe_d <= strobe every cycle.
- Channel load: load_i = ld & en[i]. Any number of channels may load in the same cycle from the same d.
- DOUBLE_BUF=0:
  - On load_i, q_i <= d and qn_i <= ~d at that sys_clk edge.
  - q is valid one cycle after the cycle where strobe is first sampled high.
  - commit has no effect; pending stays 0; overrun stays 0.
- DOUBLE_BUF=1:
  - On load_i, stage_i <= d and pending_i <= 1.
  - On commit, every channel with pending_i=1 does q_i <= stage_i; pending_i <= 0 unless that channel also loads in the same cycle. Channels with pending_i=0 hold q.
  - Commit and load_i in the same cycle: q_i takes the OLD stage_i (if pending). stage_i takes d. pending_i ends at 1.
  - Overrun: load_i while pending_i=1 and no commit in the same cycle sets overrun_i=1. Loading while commit is asserted is not an overrun.
- overrun_clr clears all flags. When clear and set coincide, set wins (flag ends at 1).
- Level mode (STROBE_EDGE=0) with strobe held high loads every cycle. In DOUBLE_BUF=1 this raises overrun from the second consecutive load without a commit.
- No combinational path from any input to any output; all outputs are registered.
- Reset asserted mid-operation discards stage and pending contents immediately.

Decomposition:
- Shared include (defs.v): DOUBLE_BUF and STROBE_EDGE mode constants, plus the channel-slice index macro.
- Sub-module slatch_chan: holds one channel's stage, q/qn, pending and overrun. Inputs: load, commit, d, overrun_clr. Instantiated CHANNELS times by a generate loop.
- The top level holds strobe_d, the ld qualifier and output packing.

Test Plan:
- Reset with strobe=1 held, then release; d=16'hA5A5, en=4'hF, no strobe edge -> q=0, qn=all ones, pending=0 for 3 cycles.
- DOUBLE_BUF=0, en=4'b0101, d=16'h1234, strobe 0->1 held 4 cycles -> ch0 and ch2 q=16'h1234 one cycle after the edge, ch1 and ch3 stay 0, no further loads while strobe stays high.
- DOUBLE_BUF=1, load ch1 with d=16'hBEEF, then commit 2 cycles later -> pending[1]=1 until commit; q1 changes 0->BEEF only after the commit edge; pending[1]=0 afterwards.
- DOUBLE_BUF=1, ch0 loaded with 16'h0001, second edge loads 16'h0002 with no commit -> overrun[0]=1 and stays set; commit gives q0=16'h0002; overrun_clr clears it.
- Load of 16'h00FF and commit in the same cycle, with ch2 stage=16'h0011 already pending -> q2=16'h0011, stage=16'h00FF, pending[2]=1, overrun[2]=0.
- STROBE_EDGE=0, strobe high 3 cycles, DOUBLE_BUF=1, en[3]=1 -> overrun[3] set on the 2nd cycle. Assert reset asynchronously mid-burst -> all outputs return to their reset values before the next sys_clk edge.

Source files
------------

// File: rtl/slatch_bank_pkg.sv
// Shared mode constants and channel-slice helper for the slatch_bank
// register bank.
package slatch_bank_pkg;

    localparam int MODE_DIRECT  = 0;
    localparam int MODE_SHADOW  = 1;
    localparam int STROBE_LEVEL = 0;
    localparam int STROBE_RISE  = 1;

    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/slatch_chan.sv
// One channel of the latch bank: optional shadow stage, q/qn pair,
// pending and sticky overrun flags.
module slatch_chan
    import slatch_bank_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DOUBLE_BUF = MODE_SHADOW
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_commit,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_overrun_clr,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_qn,
    output logic             o_pending,
    output logic             o_overrun
);

    localparam bit SHADOW = (DOUBLE_BUF == MODE_SHADOW);

    logic [WIDTH-1:0] r_stage;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qn;
    logic             r_pending;
    logic             r_overrun;

    logic w_commit_q;
    logic w_direct_q;
    logic w_ovr_set;

    // Commit moves the old stage; a coincident load refills the stage.
    assign w_commit_q = SHADOW && i_commit && r_pending;
    assign w_direct_q = !SHADOW && i_load;
    assign w_ovr_set  = SHADOW && i_load && r_pending && !i_commit;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_stage   <= '0;
            r_q       <= '0;
            r_qn      <= '1;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_commit_q) begin
                r_q  <= r_stage;
                r_qn <= ~r_stage;
            end else if (w_direct_q) begin
                r_q  <= i_d;
                r_qn <= ~i_d;
            end
            if (SHADOW && i_load)
                r_stage <= i_d;
            r_pending <= SHADOW && (i_load || (r_pending && !i_commit));
            if (w_ovr_set)
                r_overrun <= 1'b1;
            else if (i_overrun_clr)
                r_overrun <= 1'b0;
        end
    end

    assign o_q       = r_q;
    assign o_qn      = r_qn;
    assign o_pending = r_pending;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/slatch_bank.sv
// Bank of CHANNELS enabled latches sharing one data bus and a strobe
// qualified on sys_clk, with optional shadow/commit group update.
module slatch_bank
    import slatch_bank_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int CHANNELS    = 4,
    parameter int DOUBLE_BUF  = MODE_SHADOW,
    parameter int STROBE_EDGE = STROBE_RISE
) (
    input  logic                      sys_clk,
    input  logic                      reset,
    input  logic                      strobe,
    input  logic [CHANNELS-1:0]       en,
    input  logic [WIDTH-1:0]          d,
    input  logic                      commit,
    input  logic                      overrun_clr,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS*WIDTH-1:0] qn,
    output logic [CHANNELS-1:0]       pending,
    output logic [CHANNELS-1:0]       overrun
);

    logic r_strobe_d;
    logic w_ld;

    // Reset to 1 so a strobe held high through reset is not an edge.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset)
            r_strobe_d <= 1'b1;
        else
            r_strobe_d <= strobe;
    end

    assign w_ld = (STROBE_EDGE == STROBE_RISE) ? (strobe & ~r_strobe_d)
                                               : strobe;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        localparam int LSB = ch_lsb(g, WIDTH);

        slatch_chan #(
            .WIDTH      (WIDTH),
            .DOUBLE_BUF (DOUBLE_BUF)
        ) u_chan (
            .sys_clk       (sys_clk),
            .reset         (reset),
            .i_load        (w_ld & en[g]),
            .i_commit      (commit),
            .i_d           (d),
            .i_overrun_clr (overrun_clr),
            .o_q           (q[LSB +: WIDTH]),
            .o_qn          (qn[LSB +: WIDTH]),
            .o_pending     (pending[g]),
            .o_overrun     (overrun[g])
        );
    end

endmodule

// File: tb/tb_slatch_bank.sv
// Scoreboard bench for slatch_bank: shadow/edge, direct/edge and
// shadow/level instances share one stimulus stream.
module tb_slatch_bank;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        strobe;
    logic [3:0]  en;
    logic [15:0] d;
    logic        commit;
    logic        overrun_clr;

    logic [63:0] q_o  [3];
    logic [63:0] qn_o [3];
    logic [3:0]  pd_o [3];
    logic [3:0]  ov_o [3];

    int total = 0;
    int bad   = 0;

    always #5 sys_clk = ~sys_clk;

    slatch_bank #(.WIDTH(16), .CHANNELS(4), .DOUBLE_BUF(1), .STROBE_EDGE(1)) u_db (
        .sys_clk(sys_clk), .reset(reset), .strobe(strobe), .en(en), .d(d),
        .commit(commit), .overrun_clr(overrun_clr), .q(q_o[0]), .qn(qn_o[0]),
        .pending(pd_o[0]), .overrun(ov_o[0]));

    slatch_bank #(.WIDTH(16), .CHANNELS(4), .DOUBLE_BUF(0), .STROBE_EDGE(1)) u_dir (
        .sys_clk(sys_clk), .reset(reset), .strobe(strobe), .en(en), .d(d),
        .commit(commit), .overrun_clr(overrun_clr), .q(q_o[1]), .qn(qn_o[1]),
        .pending(pd_o[1]), .overrun(ov_o[1]));

    slatch_bank #(.WIDTH(16), .CHANNELS(4), .DOUBLE_BUF(1), .STROBE_EDGE(0)) u_lvl (
        .sys_clk(sys_clk), .reset(reset), .strobe(strobe), .en(en), .d(d),
        .commit(commit), .overrun_clr(overrun_clr), .q(q_o[2]), .qn(qn_o[2]),
        .pending(pd_o[2]), .overrun(ov_o[2]));

    // Reference state: one entry per instance, per channel.
    logic [15:0] m_st [3][4];
    logic [15:0] m_q  [3][4];
    logic        m_pd [3][4];
    logic        m_ov [3][4];
    logic        m_sd [3];

    typedef struct packed {
        logic [2:0][63:0] q;
        logic [2:0][3:0]  p;
        logic [2:0][3:0]  o;
    } exp_t;

    exp_t sbq[$];

    function automatic bit is_db(input int k);
        return k != 1;
    endfunction

    function automatic bit is_edge(input int k);
        return k != 2;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_sd[k] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                m_st[k][c] = '0;
                m_q[k][c]  = '0;
                m_pd[k][c] = 1'b0;
                m_ov[k][c] = 1'b0;
            end
        end
    endtask

    task automatic model_step();
        logic ld, ldc, ovs;
        if (reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            ld = is_edge(k) ? (strobe & ~m_sd[k]) : strobe;
            m_sd[k] = strobe;
            for (int c = 0; c < 4; c++) begin
                ldc = ld & en[c];
                if (!is_db(k)) begin
                    if (ldc) m_q[k][c] = d;
                end else begin
                    ovs = ldc & m_pd[k][c] & ~commit;
                    if (commit && m_pd[k][c]) m_q[k][c] = m_st[k][c];
                    if (ldc) m_st[k][c] = d;
                    m_pd[k][c] = ldc | (m_pd[k][c] & ~commit);
                    m_ov[k][c] = ovs | (m_ov[k][c] & ~overrun_clr);
                end
            end
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 4; c++) begin
                e.q[k][c*16 +: 16] = m_q[k][c];
                e.p[k][c] = m_pd[k][c];
                e.o[k][c] = m_ov[k][c];
            end
        return e;
    endfunction

    task automatic compare_head();
        exp_t e;
        if (sbq.size() == 0) begin
            chk("sb_empty", 64'd0, 64'd1);
            return;
        end
        e = sbq.pop_front();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("q%0d", k), q_o[k], e.q[k]);
            chk($sformatf("qn%0d", k), qn_o[k], ~e.q[k]);
            chk($sformatf("pend%0d", k), {60'd0, pd_o[k]}, {60'd0, e.p[k]});
            chk($sformatf("ovr%0d", k), {60'd0, ov_o[k]}, {60'd0, e.o[k]});
        end
    endtask

    task automatic cyc(input logic s, input logic [3:0] e, input logic [15:0] dd,
                       input logic c, input logic clr);
        strobe = s; en = e; d = dd; commit = c; overrun_clr = clr;
        model_step();
        sbq.push_back(snap());
        @(posedge sys_clk);
        #1;
        compare_head();
    endtask

    initial begin
        reset = 1'b1; strobe = 1'b1; en = 4'hF; d = 16'hA5A5;
        commit = 1'b0; overrun_clr = 1'b0;
        model_reset();
        #1;
        sbq.push_back(snap());
        compare_head();
        cyc(1, 4'hF, 16'hA5A5, 0, 0);
        cyc(1, 4'hF, 16'hA5A5, 0, 0);
        reset = 1'b0;

        // Strobe held high through reset: no edge for edge-mode banks.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 4'hF, 16'hA5A5, 0, 0);
            chk("hold_q_dir", q_o[1], 64'd0);
            chk("hold_qn_db", qn_o[0], 64'hFFFF_FFFF_FFFF_FFFF);
            chk("hold_pend_db", {60'd0, pd_o[0]}, 64'd0);
        end
        cyc(0, 4'h0, 16'h0, 0, 0);

        cyc(1, 4'b0101, 16'h1234, 0, 0);
        chk("dir_first", q_o[1], 64'h0000_1234_0000_1234);
        for (int i = 0; i < 3; i++)
            cyc(1, 4'b0101, 16'h5678, 0, 0);
        chk("dir_hold", q_o[1], 64'h0000_1234_0000_1234);
        chk("db_pend02", {60'd0, pd_o[0]}, 64'h5);
        cyc(0, 4'h0, 16'h0, 1, 0);
        chk("db_commit02", q_o[0], 64'h0000_1234_0000_1234);

        cyc(1, 4'b0010, 16'hBEEF, 0, 0);
        chk("beef_pend", {63'd0, pd_o[0][1]}, 64'd1);
        cyc(0, 4'h0, 16'h0, 0, 0);
        chk("beef_noq", {48'd0, q_o[0][31:16]}, 64'd0);
        cyc(0, 4'h0, 16'h0, 1, 0);
        chk("beef_q", {48'd0, q_o[0][31:16]}, 64'hBEEF);
        chk("beef_pend0", {63'd0, pd_o[0][1]}, 64'd0);

        cyc(1, 4'b0001, 16'h0001, 0, 0);
        cyc(0, 4'h0, 16'h0, 0, 0);
        cyc(1, 4'b0001, 16'h0002, 0, 0);
        chk("ovr_set", {63'd0, ov_o[0][0]}, 64'd1);
        cyc(0, 4'h0, 16'h0, 0, 0);
        chk("ovr_sticky", {63'd0, ov_o[0][0]}, 64'd1);
        cyc(0, 4'h0, 16'h0, 1, 0);
        chk("ovr_q", {48'd0, q_o[0][15:0]}, 64'h0002);
        cyc(0, 4'h0, 16'h0, 0, 1);
        chk("ovr_clr", {63'd0, ov_o[0][0]}, 64'd0);

        cyc(1, 4'b0100, 16'h0011, 0, 0);
        cyc(0, 4'h0, 16'h0, 0, 0);
        cyc(1, 4'b0100, 16'h00FF, 1, 0);
        chk("lc_q", {48'd0, q_o[0][47:32]}, 64'h0011);
        chk("lc_pend", {63'd0, pd_o[0][2]}, 64'd1);
        chk("lc_ovr", {63'd0, ov_o[0][2]}, 64'd0);
        cyc(0, 4'h0, 16'h0, 1, 0);
        chk("lc_stage", {48'd0, q_o[0][47:32]}, 64'h00FF);

        cyc(0, 4'h0, 16'h0, 1, 1);
        cyc(1, 4'b1000, 16'h3333, 0, 0);
        chk("lvl_ovr1", {63'd0, ov_o[2][3]}, 64'd0);
        cyc(1, 4'b1000, 16'h4444, 0, 0);
        chk("lvl_ovr2", {63'd0, ov_o[2][3]}, 64'd1);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        sbq.push_back(snap());
        compare_head();
        chk("async_qn", qn_o[2], 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge sys_clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
